// File: rtl/vrf_read_pipe_pkg.sv
// Shared request-field widths, request struct and arbitration mode constants
// for the multi-port VRF read pipe.
package vrf_read_pipe_pkg;
  localparam int VS_W     = 5;
  localparam int OFFSET_W = 4;
  localparam int SRC_W    = 2;
  localparam int IDX_W    = 3;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef struct packed {
    logic [VS_W-1:0]     vs;
    logic [OFFSET_W-1:0] offset;
    logic [SRC_W-1:0]    read_source;
    logic [IDX_W-1:0]    instruction_index;
  } read_req_t;
endpackage

// File: rtl/vrf_read_rr_arbiter.sv
// Picks one eligible requester per cycle: round-robin from last_grant+1, or
// fixed lowest-index priority. The pointer only moves when the grant fires.
module vrf_read_rr_arbiter
  import vrf_read_pipe_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = ARB_RR,
  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic                 advance,
  output logic                 grant_vld,
  output logic [PW-1:0]        grant_idx
);

  logic [PW-1:0] last_grant_q, last_grant_d;

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          grant_vld = 1'b1;
          grant_idx = PW'(i);
        end
      end
    end else begin
      // Walk farthest-to-nearest so the nearest eligible port after last_grant wins.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = (int'(last_grant_q) + k) % NUM_PORTS;
        if (eligible[idx]) begin
          grant_vld = 1'b1;
          grant_idx = PW'(idx);
        end
      end
    end
    last_grant_d = advance ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_grant_q <= PW'(NUM_PORTS - 1);
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/vrf_read_pipe_multi.sv
// Shares one VRF read port among NUM_PORTS requesters; credit-gated arbitration,
// fixed-latency return pipeline and a per-port result queue.
module vrf_read_pipe_multi
  import vrf_read_pipe_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 2,
  parameter int ARB_MODE     = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  output logic [NUM_PORTS-1:0]                 req_ready,
  input  logic [NUM_PORTS-1:0][VS_W-1:0]       req_vs,
  input  logic [NUM_PORTS-1:0][OFFSET_W-1:0]   req_offset,
  input  logic [NUM_PORTS-1:0][SRC_W-1:0]      req_read_source,
  input  logic [NUM_PORTS-1:0][IDX_W-1:0]      req_instruction_index,
  output logic                                 vrf_req_valid,
  input  logic                                 vrf_req_ready,
  output logic [VS_W-1:0]                      vrf_req_vs,
  output logic [OFFSET_W-1:0]                  vrf_req_offset,
  output logic [SRC_W-1:0]                     vrf_req_read_source,
  output logic [IDX_W-1:0]                     vrf_req_instruction_index,
  input  logic [DATA_WIDTH-1:0]                vrf_read_result,
  output logic [NUM_PORTS-1:0]                 deq_valid,
  input  logic [NUM_PORTS-1:0]                 deq_ready,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] deq_bits,
  output logic                                 error
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [NUM_PORTS-1:0][CW-1:0] occ, infl, credit;
  logic [NUM_PORTS-1:0]         eligible, overflow;
  logic                         grant_vld, fire;
  logic [PW-1:0]                grant_idx;
  read_req_t                    gsel;

  logic [READ_LATENCY-1:0]         vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0][PW-1:0] port_pipe_q, port_pipe_d;
  logic                            wb_vld;
  logic [PW-1:0]                   wb_port;
  logic                            error_q, error_d;

  // occ + infl never exceeds FIFO_DEPTH, so the subtraction cannot underflow.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      credit[i]   = DEPTH_C - occ[i] - infl[i];
      eligible[i] = req_valid[i] && (credit[i] != '0);
    end
  end

  vrf_read_rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clock    (clock),
    .reset    (reset),
    .eligible (eligible),
    .advance  (fire),
    .grant_vld(grant_vld),
    .grant_idx(grant_idx)
  );

  always_comb begin
    vrf_req_valid = grant_vld && !reset;
    fire          = vrf_req_valid && vrf_req_ready;
    req_ready     = '0;
    if (fire) req_ready[grant_idx] = 1'b1;
    gsel.vs                   = req_vs[grant_idx];
    gsel.offset               = req_offset[grant_idx];
    gsel.read_source          = req_read_source[grant_idx];
    gsel.instruction_index    = req_instruction_index[grant_idx];
    vrf_req_vs                = gsel.vs;
    vrf_req_offset            = gsel.offset;
    vrf_req_read_source       = gsel.read_source;
    vrf_req_instruction_index = gsel.instruction_index;
  end

  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    port_pipe_d    = port_pipe_q;
    vld_pipe_d[0]  = fire;
    port_pipe_d[0] = grant_idx;
    for (int s = 1; s < READ_LATENCY; s++) begin
      vld_pipe_d[s]  = vld_pipe_q[s-1];
      port_pipe_d[s] = port_pipe_q[s-1];
    end
    wb_vld  = vld_pipe_q[READ_LATENCY-1];
    wb_port = port_pipe_q[READ_LATENCY-1];
    error_d = error_q || (|overflow);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      port_pipe_q <= '0;
      error_q     <= 1'b0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      port_pipe_q <= port_pipe_d;
      error_q     <= error_d;
    end
  end

  assign error = error_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] occ_q, occ_d, infl_q, infl_d;
    logic          push, pop, full, wr_en, inc;

    always_comb begin
      push   = wb_vld && (wb_port == PW'(i));
      full   = (occ_q == DEPTH_C);
      pop    = (occ_q != '0) && deq_ready[i];
      wr_en  = push && !full;
      inc    = fire && (grant_idx == PW'(i));
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      infl_d = infl_q;
      if (wr_en) begin
        mem_d[wptr_q] = vrf_read_result;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      if (wr_en && !pop)      occ_d = occ_q + 1'b1;
      else if (pop && !wr_en) occ_d = occ_q - 1'b1;
      // A dropped writeback still retires its in-flight slot.
      if (inc && !push)      infl_d = infl_q + 1'b1;
      else if (push && !inc) infl_d = infl_q - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        mem_q  <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
        occ_q  <= '0;
        infl_q <= '0;
      end else begin
        mem_q  <= mem_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        occ_q  <= occ_d;
        infl_q <= infl_d;
      end
    end

    assign occ[i]       = occ_q;
    assign infl[i]      = infl_q;
    assign overflow[i]  = push && full;
    assign deq_valid[i] = (occ_q != '0);
    assign deq_bits[i]  = mem_q[rptr_q];
  end

endmodule

// File: tb/tb_vrf_read_pipe_multi.sv
// Directed + random bench for vrf_read_pipe_multi against a queue-based model;
// a second instance in fixed-priority mode shares the stimulus.
module tb_vrf_read_pipe_multi;
  localparam int NP    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int RL    = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NP-1:0]         req_valid = '0;
  logic [NP-1:0][4:0]    req_vs = '0;
  logic [NP-1:0][3:0]    req_offset = '0;
  logic [NP-1:0][1:0]    req_read_source = '0;
  logic [NP-1:0][2:0]    req_instruction_index = '0;
  logic                  vrf_req_ready = 1'b0;
  logic [DW-1:0]         vrf_read_result = '0;
  logic [NP-1:0]         deq_ready = '0;

  logic [NP-1:0]         req_ready, fp_req_ready;
  logic                  vrf_req_valid, fp_vrf_req_valid;
  logic [4:0]            vrf_req_vs, fp_vrf_req_vs;
  logic [3:0]            vrf_req_offset, fp_vrf_req_offset;
  logic [1:0]            vrf_req_read_source, fp_vrf_req_read_source;
  logic [2:0]            vrf_req_instruction_index, fp_vrf_req_instruction_index;
  logic [NP-1:0]         deq_valid, fp_deq_valid;
  logic [NP-1:0][DW-1:0] deq_bits, fp_deq_bits;
  logic                  error, fp_error;

  always #5 clock = ~clock;

  vrf_read_pipe_multi #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                        .READ_LATENCY(RL), .ARB_MODE(0)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_vs(req_vs), .req_offset(req_offset), .req_read_source(req_read_source),
    .req_instruction_index(req_instruction_index), .vrf_req_valid(vrf_req_valid),
    .vrf_req_ready(vrf_req_ready), .vrf_req_vs(vrf_req_vs), .vrf_req_offset(vrf_req_offset),
    .vrf_req_read_source(vrf_req_read_source),
    .vrf_req_instruction_index(vrf_req_instruction_index),
    .vrf_read_result(vrf_read_result), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_bits(deq_bits), .error(error));

  vrf_read_pipe_multi #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                        .READ_LATENCY(RL), .ARB_MODE(1)) dut_fp (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_vs(req_vs), .req_offset(req_offset), .req_read_source(req_read_source),
    .req_instruction_index(req_instruction_index), .vrf_req_valid(fp_vrf_req_valid),
    .vrf_req_ready(vrf_req_ready), .vrf_req_vs(fp_vrf_req_vs),
    .vrf_req_offset(fp_vrf_req_offset), .vrf_req_read_source(fp_vrf_req_read_source),
    .vrf_req_instruction_index(fp_vrf_req_instruction_index),
    .vrf_read_result(vrf_read_result), .deq_valid(fp_deq_valid), .deq_ready(deq_ready),
    .deq_bits(fp_deq_bits), .error(fp_error));

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int last_g = NP - 1;
  int fires[NP];

  typedef struct { int port; int due; } flight_t;
  flight_t       fl[$];
  logic [DW-1:0] mq[NP][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NP; i++) begin
      req_vs[i]                = 5'($urandom);
      req_offset[i]            = 4'($urandom);
      req_read_source[i]       = 2'($urandom);
      req_instruction_index[i] = 3'($urandom);
    end
  endtask

  // Model: expected grant from credits, then apply the clock edge to the queues.
  task automatic step();
    int g, idx;
    int cnt[NP];
    logic [NP-1:0] exp_rr;
    for (int i = 0; i < NP; i++) cnt[i] = 0;
    foreach (fl[k]) cnt[fl[k].port]++;
    g = -1;
    for (int k = 1; k <= NP; k++) begin
      idx = (last_g + k) % NP;
      if (g < 0 && req_valid[idx] && (DEPTH - mq[idx].size() - cnt[idx]) > 0) g = idx;
    end
    chk("vrf_req_valid", 64'(vrf_req_valid), 64'(g >= 0));
    if (g >= 0) begin
      chk("vrf_req_vs", 64'(vrf_req_vs), 64'(req_vs[g]));
      chk("vrf_req_offset", 64'(vrf_req_offset), 64'(req_offset[g]));
      chk("vrf_req_src", 64'(vrf_req_read_source), 64'(req_read_source[g]));
      chk("vrf_req_idx", 64'(vrf_req_instruction_index), 64'(req_instruction_index[g]));
    end
    exp_rr = (g >= 0 && vrf_req_ready) ? NP'(1 << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rr));
    chk("error", 64'(error), 64'(0));
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("deq_valid%0d", i), 64'(deq_valid[i]), 64'(mq[i].size() != 0));
      if (mq[i].size() != 0) chk($sformatf("deq_bits%0d", i), 64'(deq_bits[i]), 64'(mq[i][0]));
    end
    for (int i = 0; i < NP; i++)
      if (mq[i].size() != 0 && deq_ready[i]) void'(mq[i].pop_front());
    if (fl.size() > 0 && fl[0].due == cyc) begin
      mq[fl[0].port].push_back(vrf_read_result);
      void'(fl.pop_front());
    end
    if (g >= 0 && vrf_req_ready) begin
      fl.push_back('{port: g, due: cyc + RL});
      last_g = g;
      fires[g]++;
    end
  endtask

  task automatic cyc_run();
    #1;
    step();
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_deq_valid", 64'(deq_valid), 64'(0));
    chk("rst_vrf_req_valid", 64'(vrf_req_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_fp_vrf_req_valid", 64'(fp_vrf_req_valid), 64'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      fires[i] = 0;
    end
    fl.delete();
    last_g = NP - 1;
    cyc = 0;
  endtask

  initial begin
    req_valid = '1;
    @(negedge clock);
    do_reset();

    // single port-0 read, fixed latency to deq_valid
    rand_fields();
    req_valid = 2'b01; vrf_req_ready = 1'b1; deq_ready = '0;
    cyc_run();
    req_valid = '0;
    cyc_run();
    vrf_read_result = 32'hDEADBEEF;
    cyc_run();
    vrf_read_result = 32'h0;
    #1;
    chk("lat_deq_valid", 64'(deq_valid), 64'(2'b01));
    chk("lat_deq_bits0", 64'(deq_bits[0]), 64'(32'hDEADBEEF));
    cyc_run();
    deq_ready = '1;
    cyc_run();

    // round-robin alternation from reset
    do_reset();
    req_valid = '1; vrf_req_ready = 1'b1; deq_ready = '1;
    for (int k = 0; k < 6; k++) begin
      vrf_read_result = $urandom;
      #1;
      chk("rr_alt", 64'(req_ready), 64'((k % 2) ? 2'b10 : 2'b01));
      cyc_run();
    end

    // credit exhaustion on port 0, port 1 still served
    do_reset();
    req_valid = '1; vrf_req_ready = 1'b1; deq_ready = 2'b10;
    for (int k = 0; k < 14; k++) begin
      vrf_read_result = $urandom;
      cyc_run();
    end
    chk("credit_fires0", 64'(fires[0]), 64'(4));
    chk("credit_fires1", 64'(fires[1]), 64'(10));
    deq_ready = 2'b11;
    cyc_run();
    deq_ready = 2'b10;
    fires[0] = 0;
    for (int k = 0; k < 8; k++) begin
      vrf_read_result = $urandom;
      cyc_run();
    end
    chk("credit_refill0", 64'(fires[0]), 64'(1));

    // backpressure from the VRF holds the request
    do_reset();
    rand_fields();
    req_valid = '1; vrf_req_ready = 1'b1; deq_ready = '1;
    cyc_run();
    vrf_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vrf_read_result = $urandom;
      #1;
      chk("bp_valid", 64'(vrf_req_valid), 64'(1));
      chk("bp_vs", 64'(vrf_req_vs), 64'(req_vs[1]));
      chk("bp_ready", 64'(req_ready), 64'(0));
      cyc_run();
    end
    vrf_req_ready = 1'b1;
    #1 chk("bp_after1", 64'(req_ready), 64'(2'b10));
    cyc_run();
    #1 chk("bp_after0", 64'(req_ready), 64'(2'b01));
    cyc_run();

    // reset with reads in flight
    do_reset();
    req_valid = '1; vrf_req_ready = 1'b1; deq_ready = '0;
    for (int k = 0; k < 4; k++) begin
      vrf_read_result = $urandom;
      cyc_run();
    end
    #1 chk("pre_rst_deq_valid", 64'(deq_valid), 64'(2'b11));
    vrf_read_result = 32'hBAD0BAD0;
    do_reset();
    req_valid = '0;
    for (int k = 0; k < 4; k++) cyc_run();
    req_valid = '1;
    #1 chk("post_rst_first", 64'(req_ready), 64'(2'b01));
    cyc_run();

    // fixed-priority instance: port 0 until out of credit, then port 1
    do_reset();
    req_valid = '1; vrf_req_ready = 1'b1; deq_ready = '0;
    for (int k = 0; k < 10; k++) begin
      vrf_read_result = $urandom;
      #1 chk("fp_grant", 64'(fp_req_ready), 64'((k < 4) ? 2'b01 : (k < 8) ? 2'b10 : 2'b00));
      cyc_run();
    end

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rand_fields();
      req_valid       = NP'($urandom);
      vrf_req_ready   = ($urandom_range(0, 3) != 0);
      deq_ready       = NP'($urandom);
      vrf_read_result = $urandom;
      cyc_run();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
